// File: rtl/wb_arb_rr_pkg.sv
// wb_arb_rr_pkg: shared Wishbone widths and arbiter state encoding.
// Holds the default address/data/byte-select widths and the
// IDLE/BUSY/FLUSH state type used by the arbiter.
package wb_arb_rr_pkg;
    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_BW = WB_DW / 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;
endpackage

// File: rtl/wb_arb_rr_if.sv
// wb_arb_rr_if: bundle of the NM upstream Wishbone requesters plus the single downstream port.
// Upstream:   m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i in; m_dat_o, m_ack_o, m_err_o out.
// Downstream: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o out; s_dat_i, s_ack_i, s_err_i in.
// Status:     grant_o, the one-hot current grant.
// master is the arbiter's view, slave is the view of the surrounding requesters and bus.
interface wb_arb_rr_if
    import wb_arb_rr_pkg::*;
#(
    parameter int NM = 3,
    parameter int AW = WB_AW,
    parameter int DW = WB_DW,
    parameter int BW = WB_BW
);
    logic [NM-1:0]    m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, grant_o;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*BW-1:0] m_sel_i;
    logic [DW-1:0]    m_dat_o, s_dat_o, s_dat_i;
    logic [AW-1:0]    s_adr_o;
    logic [BW-1:0]    s_sel_o;
    logic             s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
    );
    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, grant_o
    );
endinterface

// File: rtl/wb_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// req    in   NM  pending requests
// last   in   IW  index granted most recently
// onehot out  NM  first set request scanning upward from last+1 with wrap, 0 if none
// idx    out  IW  index of that request
module rr_pick #(
    parameter int NM = 3,
    parameter int IW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic [NM-1:0] onehot,
    output logic [IW-1:0] idx
);
    logic          found;
    logic [IW-1:0] j;
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        // k = NM lands back on last itself, so it is checked last
        for (int k = 1; k <= NM; k++) begin
            j = IW'((int'(last) + k) % NM);
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end
endmodule

// File: rtl/wb_arb_rr.sv
// wb_arb_rr: round-robin Wishbone arbiter with burst hold and ack/err watchdog.
// wb_clk_i  in  clock
// wb_rst_i  in  asynchronous active-high reset
// bus       wb_arb_rr_if.master: NM requesters in, one downstream master port out, grant_o status
module wb_arb_rr
    import wb_arb_rr_pkg::*;
#(
    parameter int NM      = 3,
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int BW      = WB_BW,
    parameter int TIMEOUT = 255
) (
    input logic        wb_clk_i,
    input logic        wb_rst_i,
    wb_arb_rr_if.master bus
);
    localparam int IW = $clog2(NM);
    localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t    state, state_n;
    logic [NM-1:0] grant, req, pick_oh;
    logic [IW-1:0] gidx, last, pick_idx;
    logic [WW-1:0] wdog;
    logic          busy, gcyc, gstb, quiet, expire;

    assign req = bus.m_cyc_i & bus.m_stb_i;

    rr_pick #(.NM(NM)) u_pick (
        .req    (req),
        .last   (last),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign busy  = state == BUSY;
    assign gcyc  = bus.m_cyc_i[gidx];
    assign gstb  = bus.m_stb_i[gidx];
    assign quiet = !bus.s_ack_i && !bus.s_err_i;
    // expiry steals the cycle: stb is pulled low and err is returned instead
    assign expire = (TIMEOUT > 0) && busy && gcyc && gstb && quiet && wdog == WW'(TIMEOUT - 1);

    assign bus.s_cyc_o = busy && gcyc;
    assign bus.s_stb_o = busy && gstb && !expire;
    assign bus.s_we_o  = bus.s_cyc_o && bus.m_we_i[gidx];
    assign bus.s_adr_o = bus.s_cyc_o ? bus.m_adr_i[gidx*AW +: AW] : '0;
    assign bus.s_dat_o = bus.s_cyc_o ? bus.m_dat_i[gidx*DW +: DW] : '0;
    assign bus.s_sel_o = bus.s_cyc_o ? bus.m_sel_i[gidx*BW +: BW] : '0;
    assign bus.m_dat_o = bus.s_dat_i;
    assign bus.m_ack_o = busy ? grant & {NM{bus.s_ack_i}} : '0;
    assign bus.m_err_o = busy ? grant & {NM{bus.s_err_i || expire}} : '0;
    assign bus.grant_o = grant;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = |req ? BUSY : IDLE;
            BUSY:    state_n = !gcyc ? IDLE : expire ? FLUSH : BUSY;
            FLUSH:   state_n = !gcyc ? IDLE : FLUSH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            grant <= '0;
            gidx  <= '0;
            last  <= IW'(NM - 1);
            wdog  <= '0;
        end else begin
            if (state == IDLE && state_n == BUSY) begin
                grant <= pick_oh;
                gidx  <= pick_idx;
            end
            if (state != IDLE && state_n == IDLE) begin
                grant <= '0;
                last  <= gidx;
            end
            // s_stb_o is already low on expiry, so the counter clears itself then
            wdog <= (TIMEOUT > 0 && bus.s_stb_o && quiet) ? (wdog == WW'(TIMEOUT) ? wdog : wdog + 1'b1) : '0;
        end
    end
endmodule
